// File: rtl/seq_pattern_driver.sv
// Start-edge driven pattern source for the start/a/b/stop sequence protocol.
// Emits an `a` pulse or a `b` ... `stop` pair per trigger and counts dropped triggers.
module seq_pattern_driver #(
    parameter int A_DELAY  = 1,
    parameter int STOP_GAP = 2,
    parameter int OVR_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sel,
    output logic             a,
    output logic             b,
    output logic             stop,
    output logic             busy,
    output logic             done,
    output logic [OVR_W-1:0] overrun_cnt
);

    localparam int MAX_D = (A_DELAY > STOP_GAP) ? A_DELAY : STOP_GAP;
    localparam int CNT_W = $clog2(MAX_D) + 1;

    localparam logic [CNT_W-1:0] A_LOAD  = CNT_W'(A_DELAY - 1);
    localparam logic [CNT_W-1:0] G_LOAD  = CNT_W'(STOP_GAP - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_A_WAIT,
        S_A_OUT,
        S_B_LEAD,
        S_B_GAP,
        S_B_OUT
    } state_e;

    state_e state_q, state_d;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [OVR_W-1:0] ovr_q, ovr_d;

    logic start_q;
    logic rose;
    logic accept;
    logic drop;

    logic a_q, a_d;
    logic b_q, b_d;
    logic stop_q, stop_d;
    logic busy_q, busy_d;
    logic done_q, done_d;

    assign rose = start & ~start_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ovr_q   <= '0;
            start_q <= 1'b0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            stop_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ovr_q   <= ovr_d;
            start_q <= start;
            a_q     <= a_d;
            b_q     <= b_d;
            stop_q  <= stop_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        drop    = 1'b0;
        unique case (state_q)
            S_IDLE, S_A_OUT, S_B_OUT: begin
                accept  = rose;
                state_d = S_IDLE;
            end
            S_A_WAIT: begin
                drop  = rose;
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = S_A_OUT;
                end
            end
            S_B_LEAD: begin
                drop = rose;
                if (STOP_GAP == 1) begin
                    state_d = S_B_OUT;
                end else begin
                    state_d = S_B_GAP;
                    cnt_d   = G_LOAD;
                end
            end
            S_B_GAP: begin
                drop  = rose;
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = S_B_OUT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (accept) begin
            if (sel) begin
                state_d = S_B_LEAD;
            end else if (A_DELAY == 1) begin
                state_d = S_A_OUT;
            end else begin
                state_d = S_A_WAIT;
                cnt_d   = A_LOAD;
            end
        end
    end

    // `a` trails its state by one cycle so it lands one slot after `b` would.
    always_comb begin
        a_d    = (state_q == S_A_OUT);
        b_d    = (state_d == S_B_LEAD);
        stop_d = (state_d == S_B_OUT);
        done_d = a_d | stop_d;
        busy_d = (state_d != S_IDLE) | a_d;
        ovr_d  = ovr_q;
        if (drop && (ovr_q != {OVR_W{1'b1}})) begin
            ovr_d = ovr_q + OVR_W'(1);
        end
    end

    assign a           = a_q;
    assign b           = b_q;
    assign stop        = stop_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign overrun_cnt = ovr_q;

endmodule

// File: tb/tb_seq_pattern_driver.sv
// Scoreboard bench for seq_pattern_driver: default instance plus a STOP_GAP=1 copy.
// Expected {a,b,stop,done,busy} vectors are queued per cycle and popped after each edge.
module tb_seq_pattern_driver;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       sel;
    logic       a, b, stop, busy, done;
    logic [7:0] ovr;
    logic       a1, b1, stop1, busy1, done1;
    logic [7:0] ovr1;

    logic [4:0] obs;
    logic [4:0] obs1;

    int checks = 0;
    int errors = 0;

    logic [4:0] exp_q[$];
    logic [4:0] g1_q[$];

    assign obs  = {a, b, stop, done, busy};
    assign obs1 = {a1, b1, stop1, done1, busy1};

    always #5 clk = ~clk;

    seq_pattern_driver #(
        .A_DELAY (1),
        .STOP_GAP(2),
        .OVR_W   (8)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .sel        (sel),
        .a          (a),
        .b          (b),
        .stop       (stop),
        .busy       (busy),
        .done       (done),
        .overrun_cnt(ovr)
    );

    seq_pattern_driver #(
        .A_DELAY (1),
        .STOP_GAP(1),
        .OVR_W   (8)
    ) u_gap1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .sel        (sel),
        .a          (a1),
        .b          (b1),
        .stop       (stop1),
        .busy       (busy1),
        .done       (done1),
        .overrun_cnt(ovr1)
    );

    task automatic tick(input logic s, input logic sl);
        start = s;
        sel   = sl;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [1:0] stim [7];
        logic [4:0] e;
        stim = '{2'b10, 2'b01, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00};
        repeat (3) exp_q.push_back(5'b00000);
        exp_q.push_back(5'b01001);
        exp_q.push_back(5'b00001);
        exp_q.push_back(5'b00111);
        exp_q.push_back(5'b00000);
        rst_n = 1'b0;
        foreach (stim[i]) begin
            if (i == 3) rst_n = 1'b1;
            tick(stim[i][1], stim[i][0]);
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL reset cyc%0d: got %b want %b", i, obs, e);
            end
            if (i < 3) begin
                checks++;
                if (ovr !== 8'd0 || ovr1 !== 8'd0) begin
                    errors++;
                    $display("FAIL reset_ovr cyc%0d: got %0d/%0d want 0", i, ovr, ovr1);
                end
            end
        end
    endtask

    task automatic test_branch_a();
        logic [1:0] stim [4];
        logic [4:0] e;
        stim = '{2'b10, 2'b01, 2'b01, 2'b00};
        exp_q.push_back(5'b00001);
        exp_q.push_back(5'b10011);
        exp_q.push_back(5'b00000);
        exp_q.push_back(5'b00000);
        foreach (stim[i]) begin
            tick(stim[i][1], stim[i][0]);
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL branch_a cyc%0d: got %b want %b", i, obs, e);
            end
        end
    endtask

    task automatic test_branch_b();
        logic [1:0] stim [4];
        logic [4:0] e;
        stim = '{2'b11, 2'b00, 2'b00, 2'b00};
        exp_q.push_back(5'b01001);
        exp_q.push_back(5'b00001);
        exp_q.push_back(5'b00111);
        exp_q.push_back(5'b00000);
        g1_q.push_back(5'b01001);
        g1_q.push_back(5'b00111);
        g1_q.push_back(5'b00000);
        g1_q.push_back(5'b00000);
        foreach (stim[i]) begin
            tick(stim[i][1], stim[i][0]);
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL branch_b cyc%0d: got %b want %b", i, obs, e);
            end
            e = g1_q.pop_front();
            checks++;
            if (obs1 !== e) begin
                errors++;
                $display("FAIL branch_b_gap1 cyc%0d: got %b want %b", i, obs1, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] stim [12];
        logic [4:0] e;
        stim = '{2'b10, 2'b00, 2'b10, 2'b00, 2'b00,
                 2'b11, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00};
        exp_q.push_back(5'b00001);
        exp_q.push_back(5'b10011);
        exp_q.push_back(5'b00001);
        exp_q.push_back(5'b10011);
        exp_q.push_back(5'b00000);
        exp_q.push_back(5'b01001);
        exp_q.push_back(5'b00001);
        exp_q.push_back(5'b00111);
        exp_q.push_back(5'b01001);
        exp_q.push_back(5'b00001);
        exp_q.push_back(5'b00111);
        exp_q.push_back(5'b00000);
        foreach (stim[i]) begin
            tick(stim[i][1], stim[i][0]);
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL back_to_back cyc%0d: got %b want %b", i, obs, e);
            end
        end
        checks++;
        if (ovr !== 8'd0) begin
            errors++;
            $display("FAIL back_to_back_ovr: got %0d want 0", ovr);
        end
    endtask

    task automatic test_held_start();
        logic [4:0] e;
        exp_q.push_back(5'b00001);
        exp_q.push_back(5'b10011);
        repeat (9) exp_q.push_back(5'b00000);
        for (int i = 0; i < 11; i++) begin
            tick(i < 10, 1'b0);
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL held_start cyc%0d: got %b want %b", i, obs, e);
            end
        end
    endtask

    task automatic test_overrun();
        logic [1:0] stim [4];
        logic [4:0] e;
        stim = '{2'b11, 2'b01, 2'b10, 2'b00};
        exp_q.push_back(5'b01001);
        exp_q.push_back(5'b00001);
        exp_q.push_back(5'b00111);
        exp_q.push_back(5'b00000);
        foreach (stim[i]) begin
            tick(stim[i][1], stim[i][0]);
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL overrun cyc%0d: got %b want %b", i, obs, e);
            end
        end
        checks++;
        if (ovr !== 8'd1) begin
            errors++;
            $display("FAIL overrun_one: got %0d want 1", ovr);
        end
        for (int n = 2; n <= 300; n++) begin
            tick(1'b1, 1'b1);
            tick(1'b0, 1'b1);
            tick(1'b1, 1'b1);
            tick(1'b0, 1'b1);
            if (n == 255 || n == 300) begin
                checks++;
                if (ovr !== 8'd255) begin
                    errors++;
                    $display("FAIL overrun_sat n=%0d: got %0d want 255", n, ovr);
                end
            end
        end
        tick(1'b0, 1'b0);
    endtask

    task automatic test_reset_midop();
        logic [1:0] stim [8];
        logic [4:0] e;
        stim = '{2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00};
        exp_q.push_back(5'b01001);
        exp_q.push_back(5'b00001);
        repeat (3) exp_q.push_back(5'b00000);
        exp_q.push_back(5'b00001);
        exp_q.push_back(5'b10011);
        exp_q.push_back(5'b00000);
        foreach (stim[i]) begin
            rst_n = (i != 2);
            tick(stim[i][1], stim[i][0]);
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL reset_midop cyc%0d: got %b want %b", i, obs, e);
            end
            if (i == 4) begin
                checks++;
                if (ovr !== 8'd0) begin
                    errors++;
                    $display("FAIL reset_midop_ovr: got %0d want 0", ovr);
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        sel   = 1'b0;
        test_reset();
        test_branch_a();
        test_branch_b();
        test_back_to_back();
        test_held_start();
        test_overrun();
        test_reset_midop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

endmodule
